// File: rtl/seg7_pkg.sv
// seg7: shared definitions for the 7-segment capture slice.
//
// Contents:
//   seg7_code_t               7-bit active-low segment pattern, bit0=a .. bit6=g
//   SEG7_GLYPH_0..SEG7_GLYPH_F hex glyph patterns (active-low)
//   SEG7_BLANK                all segments off
package seg7;

    typedef logic [6:0] seg7_code_t;

    // Patterns are written as seg[6:0] = g f e d c b a, with 0 = segment lit.
    localparam seg7_code_t SEG7_GLYPH_0 = 7'b1000000;
    localparam seg7_code_t SEG7_GLYPH_1 = 7'b1111001;
    localparam seg7_code_t SEG7_GLYPH_2 = 7'b0100100;
    localparam seg7_code_t SEG7_GLYPH_3 = 7'b0110000;
    localparam seg7_code_t SEG7_GLYPH_4 = 7'b0011001;
    localparam seg7_code_t SEG7_GLYPH_5 = 7'b0010010;
    localparam seg7_code_t SEG7_GLYPH_6 = 7'b0000010;
    localparam seg7_code_t SEG7_GLYPH_7 = 7'b1111000;
    localparam seg7_code_t SEG7_GLYPH_8 = 7'b0000000;
    localparam seg7_code_t SEG7_GLYPH_9 = 7'b0010000;
    localparam seg7_code_t SEG7_GLYPH_A = 7'b0001000;
    localparam seg7_code_t SEG7_GLYPH_B = 7'b0000011;
    localparam seg7_code_t SEG7_GLYPH_C = 7'b1000110;
    localparam seg7_code_t SEG7_GLYPH_D = 7'b0100001;
    localparam seg7_code_t SEG7_GLYPH_E = 7'b0000110;
    localparam seg7_code_t SEG7_GLYPH_F = 7'b0001110;

    localparam seg7_code_t SEG7_BLANK   = 7'h7F;

endpackage

// File: rtl/seg7x_inv.sv
// seg7x_inv: combinational inverse of the hex 7-segment encoder.
//
// Ports:
//   pattern   in   7  active-low segment pattern (bit0=a .. bit6=g)
//   nibble    out  4  decoded hex value (0 when not a glyph)
//   is_glyph  out  1  pattern exactly matches one of the 16 hex glyphs
//   is_blank  out  1  pattern is all segments off
module seg7x_inv
    import seg7::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       is_glyph,
    output logic       is_blank
);

    // Exact match only: a single stray segment makes the pattern invalid.
    always_comb begin
        nibble   = 4'h0;
        is_glyph = 1'b1;
        is_blank = 1'b0;
        case (pattern)
            SEG7_GLYPH_0: nibble = 4'h0;
            SEG7_GLYPH_1: nibble = 4'h1;
            SEG7_GLYPH_2: nibble = 4'h2;
            SEG7_GLYPH_3: nibble = 4'h3;
            SEG7_GLYPH_4: nibble = 4'h4;
            SEG7_GLYPH_5: nibble = 4'h5;
            SEG7_GLYPH_6: nibble = 4'h6;
            SEG7_GLYPH_7: nibble = 4'h7;
            SEG7_GLYPH_8: nibble = 4'h8;
            SEG7_GLYPH_9: nibble = 4'h9;
            SEG7_GLYPH_A: nibble = 4'hA;
            SEG7_GLYPH_B: nibble = 4'hB;
            SEG7_GLYPH_C: nibble = 4'hC;
            SEG7_GLYPH_D: nibble = 4'hD;
            SEG7_GLYPH_E: nibble = 4'hE;
            SEG7_GLYPH_F: nibble = 4'hF;
            SEG7_BLANK: begin
                is_glyph = 1'b0;
                is_blank = 1'b1;
            end
            default: is_glyph = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: recovers per-digit hex values from a time-multiplexed,
// active-low 7-segment display bus.
//
// Ports:
//   clk          in   1            system clock
//   reset        in   1            synchronous, active-high reset
//   seg_in       in   7            segment lines, active-low, bit0=a .. bit6=g
//   dig_sel      in   NDIGITS      digit select, active-high, one-hot or zero
//   values       out  4*NDIGITS    captured nibble per digit, digit i at [4i+3:4i]
//   valid        out  NDIGITS      digit i currently shows a decoded glyph
//   update       out  1            one-cycle pulse on each committed write/clear
//   update_idx   out  IDX_W        digit index of the latest commit (holds)
//   err_invalid  out  1            one-cycle pulse: committed pattern not glyph/blank
//   err_sel      out  1            one-cycle pulse: committed select had >1 bit set
module seg7_capture
    import seg7::*;
#(
    parameter int NDIGITS       = 6,
    parameter int STABLE_CYCLES = 4,
    localparam int IDX_W        = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6:0]             seg_in,
    input  logic [NDIGITS-1:0]     dig_sel,
    output logic [4*NDIGITS-1:0]   values,
    output logic [NDIGITS-1:0]     valid,
    output logic                   update,
    output logic [IDX_W-1:0]       update_idx,
    output logic                   err_invalid,
    output logic                   err_sel
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    seg7_code_t         s_seg;
    logic [NDIGITS-1:0] s_sel;
    logic [CNT_W-1:0]   cnt;

    logic               same;
    logic               commit;
    logic               sel_multi;
    logic [IDX_W-1:0]   sel_idx;
    logic [3:0]         dec_nibble;
    logic               dec_glyph;
    logic               dec_blank;

    seg7x_inv u_inv (
        .pattern  (s_seg),
        .nibble   (dec_nibble),
        .is_glyph (dec_glyph),
        .is_blank (dec_blank)
    );

    // The commit fires on the single edge where the counter would step from
    // STABLE_CYCLES-1 to STABLE_CYCLES; saturation keeps it from re-firing
    // however long the input holds.
    assign same   = (seg_in == s_seg) && (dig_sel == s_sel);
    assign commit = same && (cnt == CNT_W'(STABLE_CYCLES - 1));

    // x & (x-1) clears the lowest set bit, so anything left means >1 bit set.
    assign sel_multi = (s_sel & (s_sel - NDIGITS'(1))) != '0;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (s_sel[i]) sel_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_seg       <= SEG7_BLANK;
            s_sel       <= '0;
            cnt         <= '0;
            values      <= '0;
            valid       <= '0;
            update      <= 1'b0;
            update_idx  <= '0;
            err_invalid <= 1'b0;
            err_sel     <= 1'b0;
        end else begin
            s_seg       <= seg_in;
            s_sel       <= dig_sel;
            update      <= 1'b0;
            err_invalid <= 1'b0;
            err_sel     <= 1'b0;

            if (!same)
                cnt <= '0;
            else if (cnt != CNT_W'(STABLE_CYCLES))
                cnt <= cnt + 1'b1;

            // An all-zero select is the blanking gap between digits.
            if (commit && (s_sel != '0)) begin
                if (sel_multi) begin
                    err_sel <= 1'b1;
                end else if (dec_glyph || dec_blank) begin
                    for (int i = 0; i < NDIGITS; i++) begin
                        if (s_sel[i]) begin
                            values[4*i +: 4] <= dec_blank ? 4'h0 : dec_nibble;
                            valid[i]         <= dec_glyph;
                        end
                    end
                    update     <= 1'b1;
                    update_idx <= sel_idx;
                end else begin
                    err_invalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed self-checking bench for seg7_capture
// (NDIGITS=6, STABLE_CYCLES=4).
module tb_seg7_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg_in;
    logic [5:0]  dig_sel;
    logic [23:0] values;
    logic [5:0]  valid;
    logic        update;
    logic [2:0]  update_idx;
    logic        err_invalid;
    logic        err_sel;

    int checks = 0;
    int errors = 0;

    // Pulse tallies gathered by tick(); cleared at the start of each scenario.
    int n_upd;
    int n_inv;
    int n_sel;
    int last_idx;
    bit saw8;

    seg7_capture #(.NDIGITS(6), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .values      (values),
        .valid       (valid),
        .update      (update),
        .update_idx  (update_idx),
        .err_invalid (err_invalid),
        .err_sel     (err_sel)
    );

    always #5 clk = ~clk;

    task automatic clear_tally();
        n_upd = 0; n_inv = 0; n_sel = 0; last_idx = -1; saw8 = 1'b0;
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (update) begin
            n_upd++;
            last_idx = int'(update_idx);
        end
        if (err_invalid) n_inv++;
        if (err_sel) n_sel++;
        if (valid[1] && values[7:4] == 4'h8) saw8 = 1'b1;
    endtask

    task automatic hold(input logic [5:0] sel, input logic [6:0] seg, input int n);
        dig_sel = sel;
        seg_in  = seg;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; seg_in = 7'h7F; dig_sel = 6'b0;
        tick(); tick();
        reset = 1'b0;
        clear_tally();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (values !== 24'h0 || valid !== 6'h0 || update !== 1'b0 || update_idx !== 3'd0
            || err_invalid !== 1'b0 || err_sel !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: values=%h valid=%b upd=%b idx=%0d inv=%b sel=%b, want all zero",
                     values, valid, update, update_idx, err_invalid, err_sel);
        end
    endtask

    // Glyph 2 on digit 0: commit lands exactly on the fifth edge (E0+4).
    task automatic test_latency();
        clear_tally();
        hold(6'b000001, 7'b0100100, 4);
        checks++;
        if (n_upd !== 0) begin
            errors++;
            $display("[TB] FAIL early_commit: updates=%0d by E0+3, want 0", n_upd);
        end
        hold(6'b000001, 7'b0100100, 1);
        checks++;
        if (update !== 1'b1 || update_idx !== 3'd0) begin
            errors++;
            $display("[TB] FAIL commit_pulse: update=%b idx=%0d, want 1/0", update, update_idx);
        end
        checks++;
        if (values[3:0] !== 4'h2 || valid !== 6'b000001) begin
            errors++;
            $display("[TB] FAIL digit0_value: values[3:0]=%h valid=%b, want 2/000001", values[3:0], valid);
        end
        hold(6'b000001, 7'b0100100, 1);
        checks++;
        if (update !== 1'b0 || n_upd !== 1) begin
            errors++;
            $display("[TB] FAIL single_pulse: update=%b count=%0d, want 0/1", update, n_upd);
        end
    endtask

    // A short-lived 8 must be filtered; only the stable 3 is committed.
    task automatic test_ghost();
        clear_tally();
        hold(6'b000010, 7'b0000000, 2);
        hold(6'b000010, 7'b0110000, 5);
        checks++;
        if (values[7:4] !== 4'h3 || valid[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ghost_value: values[7:4]=%h valid1=%b, want 3/1", values[7:4], valid[1]);
        end
        checks++;
        if (n_upd !== 1 || saw8 !== 1'b0 || last_idx !== 1) begin
            errors++;
            $display("[TB] FAIL ghost_updates: count=%0d saw8=%b idx=%0d, want 1/0/1", n_upd, saw8, last_idx);
        end
    endtask

    task automatic test_invalid();
        clear_tally();
        hold(6'b000100, 7'b1010101, 5);
        checks++;
        if (n_inv !== 1 || n_upd !== 0 || n_sel !== 0) begin
            errors++;
            $display("[TB] FAIL invalid_pulse: inv=%0d upd=%0d sel=%0d, want 1/0/0", n_inv, n_upd, n_sel);
        end
        checks++;
        if (values !== 24'h000032 || valid !== 6'b000011) begin
            errors++;
            $display("[TB] FAIL invalid_state: values=%h valid=%b, want 000032/000011", values, valid);
        end
    endtask

    task automatic test_multi_sel();
        clear_tally();
        hold(6'b000011, 7'b1111001, 6);
        checks++;
        if (n_sel !== 1 || n_upd !== 0 || n_inv !== 0) begin
            errors++;
            $display("[TB] FAIL multisel_pulse: sel=%0d upd=%0d inv=%0d, want 1/0/0", n_sel, n_upd, n_inv);
        end
        checks++;
        if (values !== 24'h000032 || valid !== 6'b000011) begin
            errors++;
            $display("[TB] FAIL multisel_state: values=%h valid=%b, want 000032/000011", values, valid);
        end
        clear_tally();
        hold(6'b000000, 7'b1111001, 10);
        checks++;
        if (n_sel !== 0 || n_upd !== 0 || n_inv !== 0) begin
            errors++;
            $display("[TB] FAIL gap_quiet: sel=%0d upd=%0d inv=%0d, want 0/0/0", n_sel, n_upd, n_inv);
        end
    endtask

    task automatic test_blank();
        clear_tally();
        hold(6'b000001, 7'b0010010, 5);
        checks++;
        if (values[3:0] !== 4'h5 || valid[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL set5: values[3:0]=%h valid0=%b, want 5/1", values[3:0], valid[0]);
        end
        hold(6'b000010, 7'b0110000, 5);
        clear_tally();
        hold(6'b000001, 7'b1111111, 5);
        checks++;
        if (values[3:0] !== 4'h0 || valid[0] !== 1'b0 || valid[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL blank_clear: values[3:0]=%h valid=%b, want 0/xxxx10", values[3:0], valid);
        end
        checks++;
        if (n_upd !== 1 || last_idx !== 0) begin
            errors++;
            $display("[TB] FAIL blank_update: count=%0d idx=%0d, want 1/0", n_upd, last_idx);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] pat [6] = '{7'b1000110, 7'b1000000, 7'b0001110,
                                7'b0001110, 7'b0000110, 7'b0000110};
        clear_tally();
        for (int d = 5; d >= 0; d--) begin
            hold(6'b1 << d, pat[5-d], 5);
            hold(6'b0, 7'h7F, 1);
        end
        checks++;
        if (values !== 24'hC0FFEE || valid !== 6'h3F) begin
            errors++;
            $display("[TB] FAIL scan: values=%h valid=%b, want C0FFEE/111111", values, valid);
        end
        checks++;
        if (n_upd !== 6 || n_inv !== 0 || n_sel !== 0 || update_idx !== 3'd0) begin
            errors++;
            $display("[TB] FAIL scan_pulses: upd=%0d inv=%0d sel=%0d idx=%0d, want 6/0/0/0",
                     n_upd, n_inv, n_sel, update_idx);
        end
    endtask

    // Reset lands on the edge that would otherwise commit.
    task automatic test_reset_mid();
        clear_tally();
        hold(6'b000001, 7'b1111001, 4);
        reset = 1'b1;
        tick();
        checks++;
        if (values !== 24'h0 || valid !== 6'h0 || update !== 1'b0 || update_idx !== 3'd0
            || err_invalid !== 1'b0 || err_sel !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid: values=%h valid=%b upd=%b idx=%0d, want all zero",
                     values, valid, update, update_idx);
        end
        reset = 1'b0;
        clear_tally();
        hold(6'b000001, 7'b1111001, 4);
        checks++;
        if (n_upd !== 0) begin
            errors++;
            $display("[TB] FAIL reset_restart_early: updates=%0d, want 0", n_upd);
        end
        hold(6'b000001, 7'b1111001, 1);
        checks++;
        if (update !== 1'b1 || values[3:0] !== 4'h1 || valid !== 6'b000001) begin
            errors++;
            $display("[TB] FAIL reset_restart_commit: upd=%b values=%h valid=%b, want 1/000001/000001",
                     update, values, valid);
        end
    endtask

    initial begin
        reset = 1'b1; seg_in = 7'h7F; dig_sel = 6'b0;
        test_reset();
        test_latency();
        test_ghost();
        test_invalid();
        test_multi_sel();
        test_blank();
        do_reset();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
